branch_predictor_gshare: RTL and testbench
==========================================

// Module: branch_predictor_gshare
// PURPOSE
//  Parametrised dynamic branch predictor for the 5-stage pipeline. Replaces the fixed fetch-stage predictor.
//  Tagged BTB (indexed by PC) supplies target and hit; PHT of saturating counters (gshare or bimodal) supplies direction.
//  Lookup is combinational in F. Update is registered from E on branch/jump resolution, and is non-speculative.
//  Produces the E-stage mispredict flag plus lookup and mispredict statistics.
// PARAMETERS
//  DATA_WIDTH   32  address/data width
//  BTB_ENTRIES  64  BTB depth, power of 2; BI = log2(BTB_ENTRIES)
//  PHT_ENTRIES  256 PHT depth, power of 2; PI = log2(PHT_ENTRIES)
//  TAG_BITS     8   BTB tag = PC[BI+2+TAG_BITS-1 : BI+2]
//  CTR_BITS     2   PHT counter width, >=2
//  GHR_BITS     8   global history length, 1..PI
//  GSHARE       1   1: PHT idx = PC[PI+1:2] ^ GHR (zero-extended); 0: PHT idx = PC[PI+1:2]
// PORTS
//  clk               in   1        clock, rising edge
//  rst               in   1        asynchronous, active-low reset
//  PCF_i             in   DATA_WIDTH  fetch PC
//  PredictTakenF_o   out  1        predict taken (combinational)
//  PredTargetF_o     out  DATA_WIDTH  next PC: predicted target when taken, else PCF_i+4
//  GhrF_o            out  GHR_BITS current GHR; pipeline alongside the instruction to E
//  UpdateE_i         in   1        E holds a resolved branch or jump this cycle
//  IsJumpE_i         in   1        E instr is JAL/JALR (unconditional)
//  PCE_i             in   DATA_WIDTH  PC of the E instr
//  BranchTakenE_i    in   1        actual outcome (1 for jumps)
//  PCTargetE_i       in   DATA_WIDTH  actual target
//  PredictTakenE_i   in   1        prediction made in F, pipelined
//  PredTargetE_i     in   DATA_WIDTH  PredTargetF_o, pipelined
//  GhrE_i            in   GHR_BITS GhrF_o, pipelined
//  MispredictE_o     out  1        redirect request (combinational)
//  LookupCnt_o       out  32       count of cycles with UpdateE_i=1 (resolved control instrs)
//  MispredCnt_o      out  32       count of cycles with MispredictE_o=1
// BEHAVIOUR
//  Reset (rst=0, async): all BTB valid=0; PHT counters = 2^(CTR_BITS-1)-1 (weakly not-taken); GHR=0; both counters=0.
//   During reset, PredictTakenF_o=0, PredTargetF_o=PCF_i+4, MispredictE_o=0.
//  Lookup (0 latency): hit = valid[bidx] && tag match, with bidx = PCF_i[BI+1:2].
//   PredictTakenF_o = hit && (isjump[bidx] || PHT[pidx].MSB).
//  MispredictE_o = UpdateE_i && ((PredictTakenE_i != BranchTakenE_i) || (BranchTakenE_i && PredTargetE_i != PCTargetE_i)).
//  On rising edge with UpdateE_i=1:
//   - BranchTakenE_i=1: BTB[PCE bidx] <= {valid=1, tag, PCTargetE_i, IsJumpE_i}. Overwrites any aliased entry.
//   - BranchTakenE_i=0: BTB unchanged.
//   - !IsJumpE_i: PHT at pidx(PCE_i, GhrE_i) saturating +1 if taken, -1 if not. Clamp at 0 and at 2^CTR_BITS-1.
//     Also GHR <= {GHR[GHR_BITS-2:0], BranchTakenE_i}.
//   - Jumps never touch PHT or GHR.
//   - LookupCnt_o += 1. MispredCnt_o += MispredictE_o. Both saturate at 32'hFFFF_FFFF, no wrap.
//  UpdateE_i=0: no state change.
//  Same-cycle lookup and update of one entry: lookup sees pre-update state (no bypass). The update lands at the edge.
//  Pipeline stalls/flushes: no effect on state. The caller gates UpdateE_i with a valid, non-flushed E instr.
//  PC[1:0] ignored. PCF_i+4 wraps modulo 2^DATA_WIDTH.
//  Reset mid-update: reset wins; the update is discarded.
// TESTING
//  1 Reset, PCF_i=0x100 -> PredictTakenF_o=0, PredTargetF_o=0x104, counters 0.
//  2 GSHARE=0; update PCE=0x100 taken->0x80 with PredictTakenE=0
//    -> MispredictE_o=1, MispredCnt_o=1; next cycle PCF_i=0x100 -> taken, target 0x80.
//  3 GSHARE=0; 4 taken updates at 0x100, then 1 not-taken -> counter 3 then 2; still predicts taken.
//    Second not-taken -> counter 1, predicts not-taken.
//  4 JAL 0x200->0x400, one update with IsJumpE=1 -> predict taken, target 0x400; GHR and PHT unchanged.
//  5 GSHARE=1; cond. updates T,N,T -> GhrF_o=8'h05; lookup PCF_i=0x100 (PC[9:2]=0x40) reads PHT idx 0x45.
//  6 Assert rst low between edges after step 2 -> PredictTakenF_o=0 and counters=0 immediately, before the next edge.

Source files
------------

// File: rtl/branch_predictor_gshare_if.sv
// Fetch-lookup / execute-resolve bundle for the gshare branch predictor.
// The pipeline side is the master; the predictor is the slave.
interface branch_predictor_gshare_if #(
  parameter int DATA_WIDTH = 32,
  parameter int GHR_BITS   = 8
);
  logic [DATA_WIDTH-1:0] PCF_i;
  logic                  PredictTakenF_o;
  logic [DATA_WIDTH-1:0] PredTargetF_o;
  logic [GHR_BITS-1:0]   GhrF_o;
  logic                  UpdateE_i;
  logic                  IsJumpE_i;
  logic [DATA_WIDTH-1:0] PCE_i;
  logic                  BranchTakenE_i;
  logic [DATA_WIDTH-1:0] PCTargetE_i;
  logic                  PredictTakenE_i;
  logic [DATA_WIDTH-1:0] PredTargetE_i;
  logic [GHR_BITS-1:0]   GhrE_i;
  logic                  MispredictE_o;
  logic [31:0]           LookupCnt_o;
  logic [31:0]           MispredCnt_o;

  modport master (
    output PCF_i, UpdateE_i, IsJumpE_i, PCE_i,
    output BranchTakenE_i, PCTargetE_i,
    output PredictTakenE_i, PredTargetE_i, GhrE_i,
    input  PredictTakenF_o, PredTargetF_o, GhrF_o,
    input  MispredictE_o, LookupCnt_o, MispredCnt_o
  );

  modport slave (
    input  PCF_i, UpdateE_i, IsJumpE_i, PCE_i,
    input  BranchTakenE_i, PCTargetE_i,
    input  PredictTakenE_i, PredTargetE_i, GhrE_i,
    output PredictTakenF_o, PredTargetF_o, GhrF_o,
    output MispredictE_o, LookupCnt_o, MispredCnt_o
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Tagged BTB plus gshare/bimodal PHT direction predictor.
// Combinational fetch lookup, registered non-speculative update from E.
module branch_predictor_gshare #(
  parameter int DATA_WIDTH  = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int TAG_BITS    = 8,
  parameter int CTR_BITS    = 2,
  parameter int GHR_BITS    = 8,
  parameter int GSHARE      = 1
) (
  input logic clk,
  input logic rst,
  branch_predictor_gshare_if.slave bp
);
  localparam int BI = $clog2(BTB_ENTRIES);
  localparam int PI = $clog2(PHT_ENTRIES);
  localparam int TL = BI + 2;
  localparam int TH = BI + 2 + TAG_BITS - 1;

  typedef logic [DATA_WIDTH-1:0] addr_t;
  typedef logic [CTR_BITS-1:0] ctr_t;

  localparam ctr_t CtrMax  = {CTR_BITS{1'b1}};
  localparam ctr_t CtrInit = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic                btbValid  [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btbTag    [BTB_ENTRIES];
  addr_t               btbTarget [BTB_ENTRIES];
  logic                btbJump   [BTB_ENTRIES];
  ctr_t                pht       [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr;
  logic [31:0]         lookupCnt;
  logic [31:0]         mispredCnt;

  function automatic logic [PI-1:0] phtIdx(
    input addr_t pc,
    input logic [GHR_BITS-1:0] h
  );
    if (GSHARE != 0) return pc[PI+1:2] ^ PI'(h);
    else return pc[PI+1:2];
  endfunction

  logic [BI-1:0]       bidxF, bidxE;
  logic [PI-1:0]       pidxF, pidxE;
  logic [TAG_BITS-1:0] tagF, tagE;
  logic                hitF, predTakenF, mispredE;
  addr_t               pcPlus4;

  assign bidxF   = bp.PCF_i[BI+1:2];
  assign tagF    = bp.PCF_i[TH:TL];
  assign pidxF   = phtIdx(bp.PCF_i, ghr);
  assign bidxE   = bp.PCE_i[BI+1:2];
  assign tagE    = bp.PCE_i[TH:TL];
  assign pidxE   = phtIdx(bp.PCE_i, bp.GhrE_i);
  assign pcPlus4 = bp.PCF_i + DATA_WIDTH'(4);

  assign hitF = btbValid[bidxF] && (btbTag[bidxF] == tagF);
  assign predTakenF = rst && hitF &&
    (btbJump[bidxF] || pht[pidxF][CTR_BITS-1]);

  assign mispredE = rst && bp.UpdateE_i &&
    ((bp.PredictTakenE_i != bp.BranchTakenE_i) ||
     (bp.BranchTakenE_i &&
      (bp.PredTargetE_i != bp.PCTargetE_i)));

  assign bp.PredictTakenF_o = predTakenF;
  assign bp.PredTargetF_o   = predTakenF ? btbTarget[bidxF] : pcPlus4;
  assign bp.GhrF_o          = ghr;
  assign bp.MispredictE_o   = mispredE;
  assign bp.LookupCnt_o     = lookupCnt;
  assign bp.MispredCnt_o    = mispredCnt;

  // Tag/target/jump storage is only meaningful once valid is set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btbValid[i] <= 1'b0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CtrInit;
      ghr        <= '0;
      lookupCnt  <= '0;
      mispredCnt <= '0;
    end else if (bp.UpdateE_i) begin
      if (bp.BranchTakenE_i) begin
        btbValid[bidxE]  <= 1'b1;
        btbTag[bidxE]    <= tagE;
        btbTarget[bidxE] <= bp.PCTargetE_i;
        btbJump[bidxE]   <= bp.IsJumpE_i;
      end
      if (!bp.IsJumpE_i) begin
        if (bp.BranchTakenE_i && pht[pidxE] != CtrMax)
          pht[pidxE] <= pht[pidxE] + 1'b1;
        else if (!bp.BranchTakenE_i && pht[pidxE] != '0)
          pht[pidxE] <= pht[pidxE] - 1'b1;
        ghr <= GHR_BITS'({ghr, bp.BranchTakenE_i});
      end
      if (lookupCnt != '1)
        lookupCnt <= lookupCnt + 32'd1;
      if (mispredE && mispredCnt != '1)
        mispredCnt <= mispredCnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed scoreboard bench: bimodal and gshare predictor instances.
// Expectations are queued as stimulus is driven and drained on observation.
module tb_branch_predictor_gshare;
  typedef logic [31:0] addr_t;

  localparam int PT  = 0;
  localparam int TGT = 1;
  localparam int GHR = 2;
  localparam int MIS = 3;
  localparam int LC  = 4;
  localparam int MC  = 5;
  localparam int D1  = 8;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  branch_predictor_gshare_if #(.DATA_WIDTH(32), .GHR_BITS(8)) if0 ();
  branch_predictor_gshare_if #(.DATA_WIDTH(32), .GHR_BITS(8)) if1 ();

  branch_predictor_gshare #(.GSHARE(0)) dut0 (
    .clk(clk), .rst(rst), .bp(if0.slave)
  );
  branch_predictor_gshare #(.GSHARE(1)) dut1 (
    .clk(clk), .rst(rst), .bp(if1.slave)
  );

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      PT:       return 32'(if0.PredictTakenF_o);
      TGT:      return if0.PredTargetF_o;
      GHR:      return 32'(if0.GhrF_o);
      MIS:      return 32'(if0.MispredictE_o);
      LC:       return if0.LookupCnt_o;
      MC:       return if0.MispredCnt_o;
      D1 + PT:  return 32'(if1.PredictTakenF_o);
      D1 + TGT: return if1.PredTargetF_o;
      D1 + GHR: return 32'(if1.GhrF_o);
      D1 + MIS: return 32'(if1.MispredictE_o);
      D1 + LC:  return if1.LookupCnt_o;
      D1 + MC:  return if1.MispredCnt_o;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input int sel, input logic [31:0] e,
                      input string tag);
    exp_t x;
    x.sel = sel;
    x.exp = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs(x.sel);
      checks++;
      assert (o === x.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic look(input int d, input addr_t pc);
    if (d == 0) if0.PCF_i = pc;
    else if1.PCF_i = pc;
  endtask

  task automatic upd(input int d, input addr_t pc, input bit tk,
                     input addr_t tgt, input bit jmp, input bit pt,
                     input addr_t ptgt, input logic [7:0] g);
    if (d == 0) begin
      if0.UpdateE_i = 1'b1; if0.PCE_i = pc;
      if0.BranchTakenE_i = tk; if0.PCTargetE_i = tgt;
      if0.IsJumpE_i = jmp; if0.PredictTakenE_i = pt;
      if0.PredTargetE_i = ptgt; if0.GhrE_i = g;
    end else begin
      if1.UpdateE_i = 1'b1; if1.PCE_i = pc;
      if1.BranchTakenE_i = tk; if1.PCTargetE_i = tgt;
      if1.IsJumpE_i = jmp; if1.PredictTakenE_i = pt;
      if1.PredTargetE_i = ptgt; if1.GhrE_i = g;
    end
  endtask

  task automatic idle();
    if0.UpdateE_i = 1'b0;
    if1.UpdateE_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;
    idle();
    upd(0, '0, 0, '0, 0, 0, '0, '0);
    upd(1, '0, 0, '0, 0, 0, '0, '0);
    idle();
    look(0, 32'h100);
    look(1, 32'h100);
    #3;
    push(PT, 0, "rst_pt");
    push(TGT, 32'h104, "rst_tgt");
    push(LC, 0, "rst_lcnt");
    push(MC, 0, "rst_mcnt");
    push(MIS, 0, "rst_mis");
    push(GHR, 0, "rst_ghr");
    drain();
    @(negedge clk);
    rst = 1'b1;

    // first taken update, predicted not-taken
    upd(0, 32'h100, 1, 32'h80, 0, 0, 32'h104, 8'h00);
    #1;
    push(MIS, 1, "s2_mis");
    push(PT, 0, "s2_nobypass");
    drain();
    tick(); idle(); #1;
    push(PT, 1, "s2_pt");
    push(TGT, 32'h80, "s2_tgt");
    push(MC, 1, "s2_mcnt");
    push(LC, 1, "s2_lcnt");
    push(MIS, 0, "s2_mis_idle");
    push(GHR, 1, "s2_ghr");
    drain();

    // saturate at 3, then walk back down
    for (int i = 0; i < 3; i++) begin
      upd(0, 32'h100, 1, 32'h80, 0, 1, 32'h80, 8'h00);
      #1;
      push(MIS, 0, "s3_mis_ok");
      drain();
      tick();
    end
    idle(); #1;
    push(PT, 1, "s3_pt_sat");
    push(LC, 4, "s3_lcnt");
    drain();
    upd(0, 32'h100, 0, 32'h104, 0, 1, 32'h80, 8'h00);
    #1;
    push(MIS, 1, "s3_mis_nt1");
    drain();
    tick(); idle(); #1;
    push(PT, 1, "s3_pt_ctr2");
    push(TGT, 32'h80, "s3_tgt_ctr2");
    drain();
    upd(0, 32'h100, 0, 32'h104, 0, 1, 32'h80, 8'h00);
    tick(); idle(); #1;
    push(PT, 0, "s3_pt_ctr1");
    push(TGT, 32'h104, "s3_tgt_ctr1");
    push(LC, 6, "s3_lcnt2");
    push(MC, 3, "s3_mcnt2");
    push(GHR, 32'h3C, "s3_ghr");
    drain();

    // direction right, target wrong
    upd(0, 32'h100, 1, 32'h90, 0, 1, 32'h80, 8'h00);
    #1;
    push(MIS, 1, "tgt_mis");
    drain();
    tick(); idle(); #1;
    push(PT, 1, "tgt_pt");
    push(TGT, 32'h90, "tgt_new");
    push(MC, 4, "tgt_mcnt");
    push(GHR, 32'h79, "tgt_ghr");
    drain();

    // JAL aliases BTB slot of 0x100
    upd(0, 32'h200, 1, 32'h400, 1, 0, 32'h204, 8'h00);
    #1;
    push(MIS, 1, "jal_mis");
    drain();
    tick(); idle();
    look(0, 32'h200); #1;
    push(PT, 1, "jal_pt");
    push(TGT, 32'h400, "jal_tgt");
    push(GHR, 32'h79, "jal_ghr");
    push(LC, 8, "jal_lcnt");
    push(MC, 5, "jal_mcnt");
    drain();
    look(0, 32'h100); #1;
    push(PT, 0, "alias_pt");
    push(TGT, 32'h104, "alias_tgt");
    drain();
    look(0, 32'h1200); #1;
    push(PT, 0, "tagmiss_pt");
    push(TGT, 32'h1204, "tagmiss_tgt");
    drain();
    look(0, 32'hFFFF_FFFC); #1;
    push(TGT, 32'h0, "wrap_tgt");
    drain();
    tick(); tick();
    push(LC, 8, "idle_lcnt");
    push(MC, 5, "idle_mcnt");
    drain();

    // reset between edges beats a pending update
    look(0, 32'h200);
    upd(0, 32'h200, 1, 32'h500, 1, 1, 32'h400, 8'h00);
    #1;
    push(MIS, 1, "r6_mis_pre");
    drain();
    #2 rst = 1'b0;
    #1;
    push(PT, 0, "r6_pt");
    push(TGT, 32'h204, "r6_tgt");
    push(MIS, 0, "r6_mis");
    push(LC, 0, "r6_lcnt");
    push(MC, 0, "r6_mcnt");
    push(GHR, 0, "r6_ghr");
    drain();
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    push(PT, 0, "r6_post_pt");
    push(LC, 0, "r6_post_lcnt");
    drain();

    // gshare: train PHT[0x40^0x05], then steer GHR to 0x05
    upd(1, 32'h100, 1, 32'h80, 0, 0, 32'h104, 8'h05);
    tick();
    pat = 8'b0000_0101;
    for (int i = 7; i >= 0; i--) begin
      upd(1, 32'h344, pat[i], pat[i] ? 32'h380 : 32'h348,
          0, 0, 32'h348, 8'h00);
      tick();
    end
    idle();
    look(1, 32'h100); #1;
    push(D1 + GHR, 32'h05, "g5_ghr");
    push(D1 + PT, 1, "g5_pt");
    push(D1 + TGT, 32'h80, "g5_tgt");
    push(D1 + LC, 9, "g5_lcnt");
    push(D1 + MC, 3, "g5_mcnt");
    push(GHR, 0, "g5_iso_ghr");
    drain();
    upd(1, 32'h344, 0, 32'h348, 0, 0, 32'h348, 8'h00);
    tick(); idle(); #1;
    push(D1 + GHR, 32'h0A, "g6_ghr");
    push(D1 + PT, 0, "g6_pt");
    push(D1 + TGT, 32'h104, "g6_tgt");
    push(D1 + LC, 10, "g6_lcnt");
    push(D1 + MC, 3, "g6_mcnt");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
